// File: rtl/laser_feeder.sv
// laser_feeder: buffers NPTS 4-bit points, streams them to a circle solver, then
// counts how many buffered points fall inside either of the two returned circles.
module laser_feeder #(
    parameter int          NPTS = 40,
    parameter logic [15:0] TMO  = 16'd20000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       WR_EN,
    input  logic [5:0] WR_ADDR,
    input  logic [3:0] WR_X,
    input  logic [3:0] WR_Y,
    input  logic       START,
    output logic       BUSY,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic [3:0] R1X,
    output logic [3:0] R1Y,
    output logic [3:0] R2X,
    output logic [3:0] R2Y,
    output logic [5:0] COVER,
    output logic       RES_VALID,
    output logic       TIMEOUT
);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CHECK, S_REPORT} state_t;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } pt_t;

    state_t      state, state_nx;
    pt_t         pbuf [NPTS];
    pt_t         xy, first_pt, nxt_pt, chk_pt;
    logic [5:0]  idx, idx_inc;
    logic [15:0] wcnt;
    logic        last_idx, wr_ok, hit;

    // Squared-distance test; the sum is kept 9 bits wide so 15^2+15^2 cannot alias small.
    function automatic logic near(input logic [3:0] px, input logic [3:0] py,
                                  input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx, dy;
        logic [7:0] sx, sy;
        logic [8:0] d2;
        dx   = (px > cx) ? px - cx : cx - px;
        dy   = (py > cy) ? py - cy : cy - py;
        sx   = {4'd0, dx} * {4'd0, dx};
        sy   = {4'd0, dy} * {4'd0, dy};
        d2   = {1'b0, sx} + {1'b0, sy};
        near = (d2 <= 9'd16);
    endfunction

    assign last_idx = (idx == 6'(NPTS - 1));
    assign idx_inc  = idx + 6'd1;
    assign wr_ok    = (state == S_IDLE) && WR_EN && (WR_ADDR < 6'(NPTS));
    // A write to entry 0 in the START cycle is forwarded so the new value goes out first.
    assign first_pt = (wr_ok && WR_ADDR == 6'd0) ? pt_t'({WR_X, WR_Y}) : pbuf[0];
    assign nxt_pt   = pbuf[idx_inc];
    assign chk_pt   = pbuf[idx];
    assign hit      = near(chk_pt.x, chk_pt.y, R1X, R1Y) || near(chk_pt.x, chk_pt.y, R2X, R2Y);

    assign BUSY = (state != S_IDLE);
    assign X    = xy.x;
    assign Y    = xy.y;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (START) state_nx = S_SEND;
            S_SEND:   if (last_idx) state_nx = S_WAIT;
            S_WAIT: begin
                if (DONE)                     state_nx = S_CHECK;
                else if (wcnt == TMO - 16'd1) state_nx = S_IDLE;
            end
            S_CHECK:  if (last_idx) state_nx = S_REPORT;
            S_REPORT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NPTS; i++) pbuf[i] <= '0;
        end else if (wr_ok) begin
            pbuf[WR_ADDR] <= {WR_X, WR_Y};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx       <= '0;
            wcnt      <= '0;
            xy        <= '0;
            R1X       <= '0;
            R1Y       <= '0;
            R2X       <= '0;
            R2Y       <= '0;
            COVER     <= '0;
            RES_VALID <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (START) begin
                    idx       <= '0;
                    COVER     <= '0;
                    RES_VALID <= 1'b0;
                    TIMEOUT   <= 1'b0;
                    xy        <= first_pt;
                end
                S_SEND: begin
                    if (last_idx) begin
                        xy   <= '0;
                        idx  <= '0;
                        wcnt <= '0;
                    end else begin
                        xy  <= nxt_pt;
                        idx <= idx_inc;
                    end
                end
                S_WAIT: begin
                    if (DONE) begin
                        R1X <= C1X;
                        R1Y <= C1Y;
                        R2X <= C2X;
                        R2Y <= C2Y;
                        idx <= '0;
                    end else if (wcnt == TMO - 16'd1) begin
                        TIMEOUT <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                S_CHECK: begin
                    COVER <= COVER + {5'd0, hit};
                    idx   <= last_idx ? 6'd0 : idx_inc;
                end
                S_REPORT: RES_VALID <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_feeder.sv
// Directed bench for laser_feeder: frame streaming, coverage scoring, timeout,
// ignored writes/DONE pulses and mid-frame reset.
module tb_laser_feeder;
    localparam int NPTS = 40;

    logic       CLK = 1'b0, RST_N = 1'b0;
    logic       WR_EN = 1'b0, START = 1'b0, DONE = 1'b0;
    logic [5:0] WR_ADDR = '0;
    logic [3:0] WR_X = '0, WR_Y = '0, C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
    logic       BUSY, RES_VALID, TIMEOUT;
    logic [3:0] X, Y, R1X, R1Y, R2X, R2Y;
    logic [5:0] COVER;

    int n_tests = 0, n_fail = 0;
    int lat, bad;
    logic [3:0] sx [NPTS], sy [NPTS], kx [NPTS], ky [NPTS];

    laser_feeder #(.NPTS(NPTS), .TMO(16'd100)) dut (
        .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_X(WR_X), .WR_Y(WR_Y),
        .START(START), .BUSY(BUSY), .X(X), .Y(Y), .DONE(DONE),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .R1X(R1X), .R1Y(R1Y), .R2X(R2X), .R2Y(R2Y),
        .COVER(COVER), .RES_VALID(RES_VALID), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [3:0] x, input logic [3:0] y);
        WR_EN = 1'b1; WR_ADDR = 6'(a); WR_X = x; WR_Y = y;
        tick();
        WR_EN = 1'b0;
    endtask

    // Runs one frame; DONE is raised in the w-th WAIT cycle (w=0: never). lat counts
    // edges from the start of the START cycle until RES_VALID or TIMEOUT is seen.
    task automatic run_frame(input int w, input int early_k, input logic wr_send,
                             input logic [3:0] ax, input logic [3:0] ay,
                             input logic [3:0] bx, input logic [3:0] by, output int l);
        START = 1'b1; l = 0;
        tick(); l++;
        START = 1'b0; WR_EN = 1'b0;
        chk("start_clr_res_valid", RES_VALID, 0);
        chk("start_clr_timeout", TIMEOUT, 0);
        for (int k = 0; k < NPTS; k++) begin
            sx[k] = X; sy[k] = Y;
            if (!BUSY) bad++;
            WR_EN = wr_send; WR_ADDR = 6'd39; WR_X = 4'd7; WR_Y = 4'd7;
            DONE = (k == early_k);
            C1X = 4'd1; C1Y = 4'd1; C2X = 4'd2; C2Y = 4'd2;
            tick(); l++;
            DONE = 1'b0; WR_EN = 1'b0;
        end
        chk("wait_xy_zero", {X, Y}, 0);
        for (int i = 1; i <= w; i++) begin
            if (i == w) begin
                DONE = 1'b1; C1X = ax; C1Y = ay; C2X = bx; C2Y = by;
            end
            tick(); l++;
            DONE = 1'b0; C1X = 0; C1Y = 0; C2X = 0; C2Y = 0;
        end
        while (!RES_VALID && !TIMEOUT && l < 400) begin
            tick(); l++;
        end
    endtask

    initial begin
        #12;
        chk("rst_busy", BUSY, 0);
        chk("rst_xy", {X, Y}, 0);
        chk("rst_flags", {RES_VALID, TIMEOUT}, 0);
        chk("rst_cover", COVER, 0);
        chk("rst_centres", {R1X, R1Y, R2X, R2Y}, 0);
        @(posedge CLK); #1 RST_N = 1'b1;
        tick();

        // Frame 1: all points (5,5), centres (5,5),(0,0), DONE in 4th WAIT cycle.
        for (int a = 0; a < NPTS; a++) wr(a, 4'd5, 4'd5);
        bad = 0;
        run_frame(4, -1, 1'b0, 4'd5, 4'd5, 4'd0, 4'd0, lat);
        for (int k = 0; k < NPTS; k++) if (sx[k] != 4'd5 || sy[k] != 4'd5) bad++;
        chk("f1_stream", bad, 0);
        chk("f1_latency", lat, 86);
        chk("f1_cover", COVER, 40);
        chk("f1_r1", {R1X, R1Y}, {4'd5, 4'd5});
        chk("f1_r2", {R2X, R2Y}, 0);
        chk("f1_valid", RES_VALID, 1);
        chk("f1_busy", BUSY, 0);
        tick(); tick();
        chk("f1_valid_held", RES_VALID, 1);

        // Frame 2: boundary points around (8,8); entry 0 written in the START cycle.
        wr(1, 4'd11, 4'd10); wr(2, 4'd10, 4'd11); wr(3, 4'd8, 4'd12);
        wr(4, 4'd11, 4'd11); wr(5, 4'd12, 4'd9); wr(6, 4'd10, 4'd12);
        for (int a = 7; a < NPTS; a++) wr(a, 4'd0, 4'd15);
        WR_EN = 1'b1; WR_ADDR = 6'd0; WR_X = 4'd12; WR_Y = 4'd8;
        bad = 0;
        run_frame(1, -1, 1'b0, 4'd8, 4'd8, 4'd15, 4'd0, lat);
        chk("f2_busy_send", bad, 0);
        chk("f2_first_pt", {sx[0], sy[0]}, {4'd12, 4'd8});
        chk("f2_pt4", {sx[4], sy[4]}, {4'd11, 4'd11});
        chk("f2_last_pt", {sx[39], sy[39]}, {4'd0, 4'd15});
        chk("f2_latency", lat, 83);
        chk("f2_cover", COVER, 4);
        chk("f2_r2", {R2X, R2Y}, {4'd15, 4'd0});
        for (int k = 0; k < NPTS; k++) begin kx[k] = sx[k]; ky[k] = sy[k]; end

        // Frame 3: out-of-range write, writes during SEND, early DONE during SEND.
        wr(45, 4'd3, 4'd3);
        tick();
        run_frame(3, 10, 1'b1, 4'd8, 4'd8, 4'd15, 4'd0, lat);
        bad = 0;
        for (int k = 0; k < NPTS; k++) if (sx[k] != kx[k] || sy[k] != ky[k]) bad++;
        chk("f3_stream_same", bad, 0);
        chk("f3_latency", lat, 85);
        chk("f3_r1_real_done", {R1X, R1Y}, {4'd8, 4'd8});
        chk("f3_cover", COVER, 4);

        // Frame 4: no DONE, timeout after 100 WAIT cycles.
        run_frame(0, -1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, lat);
        chk("f4_latency", lat, 141);
        chk("f4_timeout", TIMEOUT, 1);
        chk("f4_valid", RES_VALID, 0);
        chk("f4_busy", BUSY, 0);

        // Frame 5: reset at SEND k=20, then restart from a cleared buffer.
        START = 1'b1; tick(); START = 1'b0;
        repeat (20) tick();
        chk("f5_pt20", {X, Y}, {4'd0, 4'd15});
        RST_N = 1'b0;
        #1;
        chk("f5_rst_xy", {X, Y}, 0);
        chk("f5_rst_busy", BUSY, 0);
        chk("f5_rst_r1", {R1X, R1Y}, 0);
        #3 RST_N = 1'b1;
        tick();
        chk("f5_idle", BUSY, 0);
        wr(0, 4'd6, 4'd9);
        run_frame(2, -1, 1'b0, 4'd6, 4'd9, 4'd15, 4'd15, lat);
        chk("f5_first_pt", {sx[0], sy[0]}, {4'd6, 4'd9});
        chk("f5_cleared_pt", {sx[1], sy[1]}, 0);
        chk("f5_latency", lat, 84);
        chk("f5_cover", COVER, 1);
        chk("f5_valid", RES_VALID, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
